frame_pacer: RTL and testbench
==============================

Name: frame_pacer

Overview:
- Playback scheduler for the video path. Turns the synchronized VGA vsync level and the play button level into internal edge events.
- Paces frame advance at one frame per VSYNC_PER_FRAME vsync pulses.
- Requests each next frame from the frame loader over a req/ack handshake into the back buffer, then swaps the front/back buffers on a frame boundary.
- Sits between the sync generator / input conditioning and the frame loader / pixel reader.

Parameters:
- VSYNC_PER_FRAME, 2, vsync rising edges per displayed frame (60 Hz -> 30 fps); legal range 1..15.
- FRAME_COUNT, 6572, total frames in the clip; legal range 2..2^FRAME_W.
- FRAME_W, 13, width of the frame index.

Ports:
- sample_clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- vsync_in  input  1  vsync level, already synchronized to sample_clk; a rising edge marks a frame boundary.
- play_btn  input  1  play/pause level, already synchronized and debounced; each rising edge is one press.
- load_ack  input  1  loader has finished writing the requested frame into the back buffer.
- load_req  output  1  request to load frame load_idx into buffer ~buf_sel.
- load_idx  output  FRAME_W  index of the frame being requested.
- buf_sel  output  1  front buffer currently scanned out.
- playing  output  1  high while advancing (not idle, paused or done).
- done  output  1  last frame has been shown.

Behaviour:
- Clock and reset: one clock (sample_clk); reset is asynchronous and active-high.
- Reset values: load_req=0, load_idx=0, buf_sel=0, playing=0, done=0, state=IDLE, vsync counter vs_cnt=0, loaded=0, pause=0, both 2-bit edge histories=00.
- Edge detection:
  - Each input has a 2-bit history shifted every cycle; rise = history 01.
  - A primed flag, cleared by reset and set after two post-reset cycles, masks all edges until set. An input held high through reset release therefore produces no edge.
  - Timing: vsync_in first sampled high at clock edge k gives rise=1 during cycle k..k+1; any registered action it causes appears at edge k+1.
- States and transitions:
  - IDLE -> LOAD on play rise, with load_idx=0 and pause=0.
  - LOAD:
    - load_req=1; load_idx is stable while load_req=1.
    - When load_ack is sampled 1, loaded=1 and load_req=0 on the next edge; go to WAIT.
    - load_ack while load_req=0 is ignored.
  - WAIT:
    - Counts vsync rises while pause=0; vs_cnt wraps at VSYNC_PER_FRAME-1.
    - Pace point: a vsync rise with vs_cnt==VSYNC_PER_FRAME-1.
    - At the pace point with loaded=1: toggle buf_sel, clear loaded, vs_cnt=0.
      - If load_idx==FRAME_COUNT-1, go to DONE.
      - Otherwise load_idx+1 and go to LOAD.
    - At the pace point with loaded=0 (late loader): no swap, vs_cnt holds at VSYNC_PER_FRAME-1; the swap happens at the first later vsync rise with loaded=1.
    - The very first frame (idx 0) follows the same rule. buf_sel first toggles at the first pace point after frame 0 is loaded.
  - DONE:
    - done=1, playing=0, buf_sel frozen (last frame stays displayed).
    - Play rise: done=0, load_idx=0, vs_cnt=0, go to LOAD.
- Pause:
  - A play rise in LOAD or WAIT toggles pause.
  - While paused: vs_cnt holds and no swaps occur; an outstanding load_req still completes on ack.
  - playing = (state is LOAD or WAIT) and not pause.
- Simultaneous events:
  - load_ack and a pace-point vsync rise in the same cycle: the ack counts as loaded, so the swap happens on that edge.
  - A play rise and a pace point in the same cycle: the pause toggle takes effect first. Pausing suppresses that swap; resuming allows it.
- Arithmetic: the load_idx increment never exceeds FRAME_COUNT-1; vs_cnt is a 4-bit counter.
- Reset mid-operation: all state returns to reset values immediately. A loader mid-transfer sees load_req drop and must abandon the transfer.

Optional Feature:
- Macro: FRAME_PACER_LATE_CNT_EN.
- Defined:
  - Adds output late_cnt [15:0], reset 0.
  - Increments once per pace point reached with loaded=0, saturating at 16'hFFFF.
  - Cleared whenever playback restarts from IDLE or DONE.
- Undefined: no late_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Basic start:
  - Stimulus: VSYNC_PER_FRAME=2, FRAME_COUNT=4; release reset, play rise, ack 3 cycles after each req.
  - Required response: load_idx sequence 0,1,2,3; buf_sel toggles on every 2nd vsync rise; done=1 after the 4th swap; playing=0 in DONE.
- Handshake:
  - Stimulus: hold load_ack=0 for 50 cycles, then pulse it.
  - Required response: load_req stays 1 with load_idx constant; load_req falls on the edge after ack is sampled. A stray ack in WAIT changes nothing.
- Late loader:
  - Stimulus: ack arrives after the pace point.
  - Required response: no swap at the pace point; swap at the next vsync rise; late_cnt=1 with FRAME_PACER_LATE_CNT_EN defined.
- Pause/resume:
  - Stimulus: play rise in WAIT, 6 vsync rises, play rise again.
  - Required response: playing=0, buf_sel and vs_cnt frozen during pause; after resume, pacing continues from the held vs_cnt.
- Edge cases:
  - Stimulus 1: play_btn and vsync_in held high through reset release.
  - Required response 1: no start and no count.
  - Stimulus 2: ack coincident with a pace-point vsync rise.
  - Required response 2: swap on that edge.
  - Stimulus 3: async reset asserted mid-LOAD.
  - Required response 3: all outputs immediately return to reset values.
- Restart:
  - Stimulus: play rise in DONE.
  - Required response: done=0, load_req=1 with load_idx=0 on the next edge; buf_sel retained.

Source files
------------

// File: rtl/frame_pacer.sv
// -----------------------------------------------------------------------------
// frame_pacer
//
// Playback scheduler for the video path. It turns the synchronized vsync level
// and the play button level into edge events. It then paces frame advance at
// one frame every VSYNC_PER_FRAME vsync rises. Each next frame is requested
// from the frame loader over a req/ack handshake into the back buffer, and the
// front/back buffers are swapped on a frame boundary.
//
// Optional build macro: FRAME_PACER_LATE_CNT_EN
//   When this macro is defined, the block adds the late_cnt output. late_cnt
//   counts the pace points that were reached before the loader had finished.
//
// Ports:
//   sample_clk  in   system clock
//   reset       in   asynchronous, active-high reset
//   vsync_in    in   vsync level (synchronized); a rising edge is a frame boundary
//   play_btn    in   play/pause level (synchronized, debounced); a rise is a press
//   load_ack    in   loader finished writing the requested frame
//   load_req    out  request to load frame load_idx into buffer ~buf_sel
//   load_idx    out  index of the frame being requested
//   buf_sel     out  front buffer currently scanned out
//   playing     out  high while advancing (LOAD/WAIT and not paused)
//   done        out  last frame has been shown
//   late_cnt    out  [15:0] late pace points, saturating (macro builds only)
// -----------------------------------------------------------------------------
module frame_pacer #(
  parameter int VSYNC_PER_FRAME = 2,
  parameter int FRAME_COUNT     = 6572,
  parameter int FRAME_W         = 13
) (
  input  logic               sample_clk,
  input  logic               reset,
  input  logic               vsync_in,
  input  logic               play_btn,
  input  logic               load_ack,
  output logic               load_req,
  output logic [FRAME_W-1:0] load_idx,
  output logic               buf_sel,
  output logic               playing,
  output logic               done
`ifdef FRAME_PACER_LATE_CNT_EN
  ,
  output logic [15:0]        late_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0]         VS_LAST  = 4'(VSYNC_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] LAST_IDX = FRAME_W'(FRAME_COUNT - 1);

  state_t             state_q, state_d;
  logic [1:0]         vs_hist_q;
  logic [1:0]         pl_hist_q;
  logic [1:0]         prime_q;
  logic [3:0]         vs_cnt_q, vs_cnt_d;
  logic               loaded_q, loaded_d;
  logic               pause_q, pause_d;
  logic [FRAME_W-1:0] idx_q, idx_d;
  logic               buf_q, buf_d;

  logic primed;
  logic vs_rise;
  logic play_rise;
  logic active;
  logic pause_eff;
  logic ack_now;
  logic loaded_eff;
  logic pace;
  logic start;

  // ---------------------------------------------------------------------------
  // Edge detection. prime_q fills with ones during the first two cycles after
  // reset. Until it is full, all edges are masked, so an input that is already
  // high when reset is released produces no edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      vs_hist_q <= 2'b00;
      pl_hist_q <= 2'b00;
      prime_q   <= 2'b00;
    end else begin
      vs_hist_q <= {vs_hist_q[0], vsync_in};
      pl_hist_q <= {pl_hist_q[0], play_btn};
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  assign primed    = prime_q[1];
  assign vs_rise   = primed && (vs_hist_q == 2'b01);
  assign play_rise = primed && (pl_hist_q == 2'b01);

  // Vsync pacing runs in both LOAD and WAIT. This lets a late loader be
  // detected while its request is still outstanding.
  assign active     = (state_q == S_LOAD) || (state_q == S_WAIT);

  // A play press in the same cycle as a pace point acts on pause first.
  assign pause_eff  = pause_q ^ (active && play_rise);
  assign ack_now    = (state_q == S_LOAD) && load_ack;

  // An ack that coincides with the pace point already counts as loaded.
  assign loaded_eff = loaded_q || ack_now;
  assign pace       = active && vs_rise && !pause_eff && (vs_cnt_q == VS_LAST);
  assign start      = play_rise && ((state_q == S_IDLE) || (state_q == S_DONE));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (play_rise) state_d = S_LOAD;
      S_LOAD: begin
        if (pace && loaded_eff) begin
          state_d = (idx_q == LAST_IDX) ? S_DONE : S_LOAD;
        end else if (ack_now) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (pace && loaded_q) begin
          state_d = (idx_q == LAST_IDX) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: if (play_rise) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    load_req = (state_q == S_LOAD);
    done     = (state_q == S_DONE);
    playing  = active && !pause_q;
    load_idx = idx_q;
    buf_sel  = buf_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath: vsync counter, loaded/pause flags, frame index and buffer select
  // ---------------------------------------------------------------------------
  always_comb begin
    vs_cnt_d = vs_cnt_q;
    loaded_d = loaded_q;
    pause_d  = pause_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    if (start) begin
      idx_d    = '0;
      vs_cnt_d = 4'd0;
      pause_d  = 1'b0;
      loaded_d = 1'b0;
    end else if (active) begin
      pause_d = pause_eff;
      if (ack_now) loaded_d = 1'b1;
      if (vs_rise && !pause_eff) begin
        if (vs_cnt_q != VS_LAST) begin
          vs_cnt_d = vs_cnt_q + 4'd1;
        end else if (loaded_eff) begin
          buf_d    = !buf_q;
          loaded_d = 1'b0;
          vs_cnt_d = 4'd0;
          if (idx_q != LAST_IDX) idx_d = idx_q + FRAME_W'(1);
        end
        // If the frame is not loaded yet, vs_cnt stays at VS_LAST. The next
        // vsync rise after the ack then swaps.
      end
    end
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      vs_cnt_q <= 4'd0;
      loaded_q <= 1'b0;
      pause_q  <= 1'b0;
      idx_q    <= '0;
      buf_q    <= 1'b0;
    end else begin
      vs_cnt_q <= vs_cnt_d;
      loaded_q <= loaded_d;
      pause_q  <= pause_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
    end
  end

`ifdef FRAME_PACER_LATE_CNT_EN
  // ---------------------------------------------------------------------------
  // Late-loader counter: counts pace points reached before the frame was loaded.
  // ---------------------------------------------------------------------------
  logic [15:0] late_q, late_d;

  always_comb begin
    late_d = late_q;
    if (start) begin
      late_d = 16'd0;
    end else if (pace && !loaded_eff && (late_q != 16'hFFFF)) begin
      late_d = late_q + 16'd1;
    end
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      late_q <= 16'd0;
    end else begin
      late_q <= late_d;
    end
  end

  assign late_cnt = late_q;
`endif

endmodule

// File: tb/tb_frame_pacer.sv
// -----------------------------------------------------------------------------
// tb_frame_pacer
//
// Directed testbench for frame_pacer with VSYNC_PER_FRAME=2 and FRAME_COUNT=4.
// Each expected load request index is queued when the stimulus that should
// cause the request is driven. The queued value is popped and compared when
// the DUT raises a new request.
// -----------------------------------------------------------------------------
module tb_frame_pacer;

  localparam int VPF = 2;
  localparam int FC  = 4;
  localparam int FW  = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync_in = 1'b0;
  logic          play_btn = 1'b0;
  logic          load_ack = 1'b0;
  logic          load_req;
  logic [FW-1:0] load_idx;
  logic          buf_sel;
  logic          playing;
  logic          done;
`ifdef FRAME_PACER_LATE_CNT_EN
  logic [15:0]   late_cnt;
`endif

  frame_pacer #(
    .VSYNC_PER_FRAME(VPF),
    .FRAME_COUNT    (FC),
    .FRAME_W        (FW)
  ) dut (
    .sample_clk(clk),
    .reset     (reset),
    .vsync_in  (vsync_in),
    .play_btn  (play_btn),
    .load_ack  (load_ack),
    .load_req  (load_req),
    .load_idx  (load_idx),
    .buf_sel   (buf_sel),
    .playing   (playing),
    .done      (done)
`ifdef FRAME_PACER_LATE_CNT_EN
    ,
    .late_cnt  (late_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            exp_q[$];
  logic          prev_req = 1'b0;
  logic [FW-1:0] prev_idx = '0;
  logic          exp_buf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard monitor: a new request (req rise or index change) pops one entry.
  task automatic monitor();
    int e;
    if (load_req === 1'b1 && (prev_req !== 1'b1 || load_idx !== prev_idx)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL req_unexpected: observed idx %0d expected no request", load_idx);
      end else begin
        e = exp_q.pop_front();
        chk("req_idx", 32'(load_idx), 32'(e));
      end
    end
    prev_req = load_req;
    prev_idx = load_idx;
  endtask

  // Advance n clock edges, then sample 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      monitor();
    end
  endtask

  // Rising vsync edge. The counting edge has happened by the time this returns.
  task automatic vs_pulse();
    vsync_in = 1'b1;
    step(2);
    vsync_in = 1'b0;
    step(2);
  endtask

  // Play press. The registered effect is visible when this returns.
  task automatic press();
    play_btn = 1'b1;
    step(2);
    play_btn = 1'b0;
  endtask

  task automatic ack_pulse();
    load_ack = 1'b1;
    step(1);
    load_ack = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},  32'(load_req), 32'(0));
    chk({tag, "_idx"},  32'(load_idx), 32'(0));
    chk({tag, "_buf"},  32'(buf_sel),  32'(0));
    chk({tag, "_play"}, 32'(playing),  32'(0));
    chk({tag, "_done"}, 32'(done),     32'(0));
`ifdef FRAME_PACER_LATE_CNT_EN
    chk({tag, "_late"}, 32'(late_cnt), 32'(0));
`endif
  endtask

  initial begin
    // ---------------- reset ----------------
    step(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    step(3);

    // ---------------- basic start: 4 frames ----------------
    exp_q.push_back(0);
    press();
    chk("start_req",  32'(load_req), 32'(1));
    chk("start_play", 32'(playing),  32'(1));
    step(1);
    for (int f = 0; f < FC; f++) begin
      step(1);
      ack_pulse();
      chk("basic_req_drop", 32'(load_req), 32'(0));
      vs_pulse();
      chk("basic_buf_hold", 32'(buf_sel), 32'(exp_buf));
      if (f < FC - 1) exp_q.push_back(f + 1);
      vs_pulse();
      exp_buf = ~exp_buf;
      chk("basic_buf_swap", 32'(buf_sel), 32'(exp_buf));
    end
    chk("done_flag", 32'(done),     32'(1));
    chk("done_play", 32'(playing),  32'(0));
    chk("done_req",  32'(load_req), 32'(0));
    vs_pulse();
    vs_pulse();
    chk("done_buf_frozen", 32'(buf_sel), 32'(exp_buf));

    // ---------------- restart from DONE ----------------
    exp_q.push_back(0);
    press();
    chk("restart_done", 32'(done),     32'(0));
    chk("restart_req",  32'(load_req), 32'(1));
    chk("restart_idx",  32'(load_idx), 32'(0));
    chk("restart_buf",  32'(buf_sel),  32'(exp_buf));

    // ---------------- handshake: long ack delay ----------------
    for (int i = 0; i < 5; i++) begin
      step(10);
      chk("hs_req_hold", 32'(load_req), 32'(1));
      chk("hs_idx_hold", 32'(load_idx), 32'(0));
    end
    ack_pulse();
    chk("hs_req_fall", 32'(load_req), 32'(0));
    step(1);
    ack_pulse();            // stray ack in WAIT
    step(1);
    chk("stray_req", 32'(load_req), 32'(0));
    chk("stray_idx", 32'(load_idx), 32'(0));
    chk("stray_buf", 32'(buf_sel),  32'(exp_buf));
    vs_pulse();
    exp_q.push_back(1);
    vs_pulse();
    exp_buf = ~exp_buf;
    chk("hs_swap", 32'(buf_sel), 32'(exp_buf));

    // ---------------- late loader ----------------
    vs_pulse();
    vs_pulse();             // pace point without ack
    chk("late_no_swap", 32'(buf_sel),  32'(exp_buf));
    chk("late_req",     32'(load_req), 32'(1));
`ifdef FRAME_PACER_LATE_CNT_EN
    chk("late_cnt_1", 32'(late_cnt), 32'(1));
`endif
    ack_pulse();
    chk("late_ack_no_swap", 32'(buf_sel), 32'(exp_buf));
    exp_q.push_back(2);
    vs_pulse();             // next rise swaps immediately
    exp_buf = ~exp_buf;
    chk("late_swap", 32'(buf_sel),  32'(exp_buf));
    chk("late_idx",  32'(load_idx), 32'(2));
`ifdef FRAME_PACER_LATE_CNT_EN
    chk("late_cnt_hold", 32'(late_cnt), 32'(1));
`endif

    // ---------------- ack coincident with pace point ----------------
    vs_pulse();             // vs_cnt = 1
    exp_q.push_back(3);
    vsync_in = 1'b1;
    step(1);                // vsync sampled high; rise active this cycle
    load_ack = 1'b1;
    step(1);                // ack and pace point on the same edge
    load_ack = 1'b0;
    exp_buf = ~exp_buf;
    chk("coinc_swap", 32'(buf_sel),  32'(exp_buf));
    chk("coinc_req",  32'(load_req), 32'(1));
    chk("coinc_idx",  32'(load_idx), 32'(3));
    vsync_in = 1'b0;
    step(2);

    // ---------------- async reset mid-LOAD ----------------
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    exp_buf = 1'b0;

    // ---------------- inputs held high through reset release ----------------
    play_btn = 1'b1;
    vsync_in = 1'b1;
    step(2);
    reset = 1'b0;
    step(5);
    chk("held_req",  32'(load_req), 32'(0));
    chk("held_play", 32'(playing),  32'(0));
    play_btn = 1'b0;
    vsync_in = 1'b0;
    step(2);

    // ---------------- pause / resume ----------------
    exp_q.push_back(0);
    press();
    chk("p_start_req", 32'(load_req), 32'(1));
    step(2);
    ack_pulse();
    vs_pulse();             // vs_cnt = 1
    chk("p_no_swap_yet", 32'(buf_sel), 32'(exp_buf));
    press();
    chk("pause_play", 32'(playing), 32'(0));
    for (int i = 0; i < 6; i++) vs_pulse();
    chk("pause_buf",  32'(buf_sel),  32'(exp_buf));
    chk("pause_req",  32'(load_req), 32'(0));
    press();
    chk("resume_play", 32'(playing), 32'(1));
    exp_q.push_back(1);
    vs_pulse();             // held vs_cnt=1: this rise is the pace point
    exp_buf = ~exp_buf;
    chk("resume_swap", 32'(buf_sel),  32'(exp_buf));
    chk("resume_idx",  32'(load_idx), 32'(1));
    chk("resume_req",  32'(load_req), 32'(1));
    step(2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
